// File: rtl/zoom_addr_sequencer_if.sv
// Bus between the zoom address sequencer, its host (start/mode/status)
// and memory_control (addr_base/operation/enable/done).
// master: the sequencer side. slave: host + memory_control side.
interface zoom_addr_sequencer_if #(
    parameter int ADDR_W = 17
);
    logic              start;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] addr_base;
    logic [2:0]        operation;
    logic              enable;
    logic              done;
    logic              busy;
    logic              finished;
    logic [23:0]       cycles;

    modport master (
        input  start, mode, done,
        output addr_base, operation, enable, busy, finished, cycles
    );

    modport slave (
        output start, mode, done,
        input  addr_base, operation, enable, busy, finished, cycles
    );
endinterface

// File: rtl/zoom_addr_sequencer.sv
// zoom_addr_sequencer: walks every destination pixel of a 2x zoom-in (NB/PR)
// or 2x zoom-out (AM/DM) and issues the source read address(es) followed by
// the destination write address to memory_control, one transaction per done.
// Optional feature macro: PERF_CNT_EN enables the busy-cycle counter on
// bus.cycles; without it cycles is tied to zero.
module zoom_addr_sequencer #(
    parameter int SRC_W    = 160,
    parameter int SRC_H    = 120,
    parameter int ADDR_W   = 17,
    parameter int DST_BASE = SRC_W * SRC_H
) (
    input logic                   clock,
    input logic                   reset,
    zoom_addr_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GAP     = 2'd2,
        DONE_ST = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  mode_lat;
    logic [15:0] dx;
    logic [15:0] dy;
    logic [2:0]  sub;
    logic        last_px;

    logic [15:0]     dw;
    logic [15:0]     dh;
    logic [2:0]      nreads;
    logic [ADDR_W:0] nxt_txn;

    // {is_write, address} of transaction number s of dest pixel (x,y) in mode m.
    // Sub-index s counts the reads; s equal to the read count is the write.
    function automatic logic [ADDR_W:0] txn_addr(
        input logic [1:0]  m,
        input logic [15:0] x,
        input logic [15:0] y,
        input logic [2:0]  s
    );
        logic [31:0] xw;
        logic [31:0] yw;
        logic [31:0] fw;
        logic [31:0] a;
        logic        wr;
        xw = {16'd0, x};
        yw = {16'd0, y};
        fw = m[1] ? 32'(SRC_W / 2) : 32'(2 * SRC_W);
        wr = (m == 2'd2) ? (s == 3'd4) : (s == 3'd1);
        if (wr) begin
            a = 32'(DST_BASE) + yw * fw + xw;
        end else if (!m[1]) begin
            a = (yw >> 1) * 32'(SRC_W) + (xw >> 1);
        end else begin
            // AM quad order b, b+1, b+W, b+W+1 falls out of the two sub bits
            a = (yw << 1) * 32'(SRC_W) + (xw << 1) + {31'd0, s[0]}
                + (s[1] ? 32'(SRC_W) : 32'd0);
        end
        return {wr, ADDR_W'(a)};
    endfunction

    // Destination geometry and the address of the next transaction to issue.
    // In IDLE the first transaction is built from the incoming mode at (0,0).
    always_comb begin
        dw      = mode_lat[1] ? 16'(SRC_W / 2) : 16'(2 * SRC_W);
        dh      = mode_lat[1] ? 16'(SRC_H / 2) : 16'(2 * SRC_H);
        nreads  = (mode_lat == 2'd2) ? 3'd4 : 3'd1;
        if (state == IDLE) begin
            nxt_txn = txn_addr(bus.mode, 16'd0, 16'd0, 3'd0);
        end else begin
            nxt_txn = txn_addr(mode_lat, dx, dy, sub);
        end
    end

    // Sequencer FSM with registered memory-request and status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            mode_lat      <= 2'd0;
            dx            <= 16'd0;
            dy            <= 16'd0;
            sub           <= 3'd0;
            last_px       <= 1'b0;
            bus.addr_base <= '0;
            bus.operation <= 3'd0;
            bus.enable    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.finished  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.finished <= 1'b0;
                    if (bus.start) begin
                        mode_lat      <= bus.mode;
                        dx            <= 16'd0;
                        dy            <= 16'd0;
                        sub           <= 3'd0;
                        last_px       <= 1'b0;
                        bus.addr_base <= nxt_txn[ADDR_W-1:0];
                        bus.operation <= {nxt_txn[ADDR_W], bus.mode};
                        bus.enable    <= 1'b1;
                        bus.busy      <= 1'b1;
                        state         <= REQ;
                    end else begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    // enable is always high here, so done alone retires
                    if (bus.done) begin
                        bus.enable <= 1'b0;
                        state      <= GAP;
                        if (sub != nreads) begin
                            sub <= sub + 3'd1;
                        end else begin
                            sub <= 3'd0;
                            if (dx == dw - 16'd1) begin
                                dx <= 16'd0;
                                dy <= dy + 16'd1;
                                if (dy == dh - 16'd1) begin
                                    last_px <= 1'b1;
                                end else begin
                                    last_px <= 1'b0;
                                end
                            end else begin
                                dx <= dx + 16'd1;
                            end
                        end
                    end else begin
                        state <= REQ;
                    end
                end
                GAP: begin
                    if (last_px) begin
                        bus.busy     <= 1'b0;
                        bus.finished <= 1'b1;
                        state        <= DONE_ST;
                    end else begin
                        bus.addr_base <= nxt_txn[ADDR_W-1:0];
                        bus.operation <= {nxt_txn[ADDR_W], mode_lat};
                        bus.enable    <= 1'b1;
                        state         <= REQ;
                    end
                end
                DONE_ST: begin
                    bus.finished <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    bus.enable   <= 1'b0;
                    bus.busy     <= 1'b0;
                    bus.finished <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

`ifdef PERF_CNT_EN
    logic [23:0] cyc_cnt;

    // Busy-cycle counter: clears on accepted start, saturates at all ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            cyc_cnt <= 24'd0;
        end else if (state == IDLE && bus.start) begin
            cyc_cnt <= 24'd0;
        end else if (bus.busy && !(&cyc_cnt)) begin
            cyc_cnt <= cyc_cnt + 24'd1;
        end else begin
            cyc_cnt <= cyc_cnt;
        end
    end

    assign bus.cycles = cyc_cnt;
`else
    assign bus.cycles = 24'd0;
`endif

endmodule

// File: tb/tb_zoom_addr_sequencer.sv
// Self-checking bench for zoom_addr_sequencer with SRC_W=4, SRC_H=2,
// DST_BASE=8. A responder answers enable with done after a programmable
// hold-off and logs every retired transaction; directed runs compare the
// log against a table of hand-computed addresses and operations.
module tb_zoom_addr_sequencer;

    localparam int AW = 17;

    logic clock = 1'b0;
    logic reset;

    zoom_addr_sequencer_if #(.ADDR_W(AW)) bus ();

    zoom_addr_sequencer #(
        .SRC_W(4), .SRC_H(2), .ADDR_W(AW), .DST_BASE(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] mode;
        int         idx;
        int         addr;
        logic [2:0] op;
    } vec_t;

    vec_t       vecs[$];
    int         log_addr[$];
    logic [2:0] log_op[$];

    int   checks = 0;
    int   failures = 0;
    bit   resp_en = 1'b0;
    int   hold = 0;
    bit   gap_poke = 1'b0;
    bit   force_done = 1'b0;
    int   fin_cnt = 0;
    int   busy_cnt = 0;
    bit   stab_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Memory-control stand-in: done after `hold` idle cycles of enable.
    initial begin : responder
        int         wait_cnt;
        int         st_addr;
        logic [2:0] st_op;
        wait_cnt = 0;
        st_addr  = 0;
        st_op    = 3'd0;
        bus.done = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.finished) fin_cnt++;
            if (bus.busy) busy_cnt++;
            if (resp_en && bus.enable) begin
                if (wait_cnt == 0) begin
                    st_addr = int'(bus.addr_base);
                    st_op   = bus.operation;
                end else if (int'(bus.addr_base) != st_addr || bus.operation != st_op) begin
                    stab_err = 1'b1;
                end
                if (wait_cnt >= hold) begin
                    bus.done = 1'b1;
                    wait_cnt = 0;
                    log_addr.push_back(int'(bus.addr_base));
                    log_op.push_back(bus.operation);
                end else begin
                    bus.done = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus.done = (gap_poke && !bus.enable) || force_done;
                wait_cnt = 0;
            end
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_op.delete();
    endtask

    task automatic pulse_start(input logic [1:0] m);
        @(negedge clock);
        bus.mode  = m;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check(name, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic compare_mode(input logic [1:0] m, input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].mode == m) begin
                if (vecs[i].idx < log_addr.size()) begin
                    check($sformatf("%s_addr%0d", tag, vecs[i].idx),
                          log_addr[vecs[i].idx], vecs[i].addr);
                    check($sformatf("%s_op%0d", tag, vecs[i].idx),
                          {29'd0, log_op[vecs[i].idx]}, {29'd0, vecs[i].op});
                end else begin
                    check($sformatf("%s_missing%0d", tag, vecs[i].idx),
                          log_addr.size(), vecs[i].idx + 1);
                end
            end
        end
    endtask

    task automatic run(input logic [1:0] m, input int h, input int total, input string tag);
        int fin0;
        clear_log();
        hold     = h;
        fin0     = fin_cnt;
        busy_cnt = 0;
        pulse_start(m);
        check({tag, "_busy_rise"}, {31'd0, bus.busy}, 32'd1);
        wait_idle({tag, "_timeout"});
        repeat (2) @(negedge clock);
        check({tag, "_finished"}, fin_cnt - fin0, 32'd1);
        check({tag, "_total"}, log_addr.size(), total);
        compare_mode(m, tag);
    endtask

    initial begin : main
        int fin0;
        int n;
        int cyc_exp;

        // DM (3): 2 pixels, R/W each
        vecs.push_back('{2'd3, 0, 0, 3'b011});
        vecs.push_back('{2'd3, 1, 8, 3'b111});
        vecs.push_back('{2'd3, 2, 2, 3'b011});
        vecs.push_back('{2'd3, 3, 9, 3'b111});
        // AM (2): 2 pixels, 4 reads + write each
        vecs.push_back('{2'd2, 0, 0, 3'b010});
        vecs.push_back('{2'd2, 1, 1, 3'b010});
        vecs.push_back('{2'd2, 2, 4, 3'b010});
        vecs.push_back('{2'd2, 3, 5, 3'b010});
        vecs.push_back('{2'd2, 4, 8, 3'b110});
        vecs.push_back('{2'd2, 5, 2, 3'b010});
        vecs.push_back('{2'd2, 6, 3, 3'b010});
        vecs.push_back('{2'd2, 7, 6, 3'b010});
        vecs.push_back('{2'd2, 8, 7, 3'b010});
        vecs.push_back('{2'd2, 9, 9, 3'b110});
        // NB (0): dest 8x4; pixel k -> txn 2k read, 2k+1 write
        vecs.push_back('{2'd0, 0, 0, 3'b000});
        vecs.push_back('{2'd0, 1, 8, 3'b100});
        vecs.push_back('{2'd0, 4, 1, 3'b000});
        vecs.push_back('{2'd0, 5, 10, 3'b100});
        vecs.push_back('{2'd0, 16, 0, 3'b000});
        vecs.push_back('{2'd0, 17, 16, 3'b100});
        vecs.push_back('{2'd0, 62, 7, 3'b000});
        vecs.push_back('{2'd0, 63, 39, 3'b100});
        // PR (1): same addresses as NB
        vecs.push_back('{2'd1, 4, 1, 3'b001});
        vecs.push_back('{2'd1, 5, 10, 3'b101});
        vecs.push_back('{2'd1, 17, 16, 3'b101});
        vecs.push_back('{2'd1, 62, 7, 3'b001});
        vecs.push_back('{2'd1, 63, 39, 3'b101});

        bus.start = 1'b0;
        bus.mode  = 2'd0;
        reset     = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_addr", {15'd0, bus.addr_base}, 32'd0);
        check("rst_op", {29'd0, bus.operation}, 32'd0);
        check("rst_enable", {31'd0, bus.enable}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_finished", {31'd0, bus.finished}, 32'd0);
        check("rst_cycles", {8'd0, bus.cycles}, 32'd0);
        reset   = 1'b0;
        resp_en = 1'b1;

        run(2'd3, 1, 4, "dm");
`ifdef PERF_CNT_EN
        cyc_exp = busy_cnt;
`else
        cyc_exp = 0;
`endif
        check("dm_cycles", {8'd0, bus.cycles}, cyc_exp);
        repeat (5) @(negedge clock);
        check("dm_cycles_hold", {8'd0, bus.cycles}, cyc_exp);

        run(2'd2, 0, 10, "am");
        run(2'd0, 1, 64, "nb");
        run(2'd1, 0, 64, "pr");

        // done held off 5 cycles: request must stay stable
        stab_err = 1'b0;
        run(2'd3, 5, 4, "holdoff");
        check("holdoff_stable", {31'd0, stab_err}, 32'd0);

        // done pulsed during GAP must not retire anything
        gap_poke = 1'b1;
        run(2'd3, 0, 4, "gapdone");
        gap_poke = 1'b0;
        repeat (2) @(negedge clock);

        // start while busy and start in DONE_ST are ignored
        clear_log();
        hold = 1;
        fin0 = fin_cnt;
        pulse_start(2'd3);
        repeat (3) @(negedge clock);
        bus.mode  = 2'd2;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        wait_idle("ign_timeout");
        bus.mode  = 2'd0;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (3) @(negedge clock);
        check("ign_busy", {31'd0, bus.busy}, 32'd0);
        check("ign_total", log_addr.size(), 32'd4);
        check("ign_finished", fin_cnt - fin0, 32'd1);
        compare_mode(2'd3, "ign");

        // start and done together in IDLE: start wins, done ignored
        clear_log();
        hold = 1;
        @(negedge clock);
        force_done = 1'b1;
        @(negedge clock);
        bus.mode  = 2'd3;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start  = 1'b0;
        force_done = 1'b0;
        wait_idle("sd_timeout");
        repeat (2) @(negedge clock);
        check("sd_total", log_addr.size(), 32'd4);
        compare_mode(2'd3, "sd");

        // reset during the 3rd transaction
        clear_log();
        hold = 3;
        fin0 = fin_cnt;
        pulse_start(2'd3);
        n = 0;
        while (log_addr.size() < 2 && n < 200) begin
            @(negedge clock);
            n++;
        end
        while (bus.enable && n < 200) begin
            @(negedge clock);
            n++;
        end
        while (!bus.enable && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("mid_reach3", log_addr.size(), 32'd2);
        reset = 1'b1;
        @(negedge clock);
        check("mid_enable", {31'd0, bus.enable}, 32'd0);
        check("mid_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        check("mid_no_finish", fin_cnt - fin0, 32'd0);
        check("mid_idle_busy", {31'd0, bus.busy}, 32'd0);
        run(2'd3, 1, 4, "restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
